// File: rtl/pcf8591_scan.sv
// pcf8591_scan: scans PCF8591 AIN0..CH_NUM-1 via the I2C driver, averages samples per channel and converts to mV.
// Ports:
//   i_clk, i_rst          driver clock (dri_clk), synchronous active-high reset
//   i_enable              scanning runs while high
//   i_dac_en, i_dac_val   DAC enable bit and code, latched at each channel's write
//   o_i2c_exec            one-cycle operation trigger to the I2C driver
//   o_i2c_rh_wl           1 = read, 0 = write
//   o_i2c_addr            control byte in [7:0], upper byte zero
//   o_i2c_data_w          DAC byte for writes
//   i_i2c_data_r          read data, valid with i_i2c_done
//   i_i2c_done            one-cycle operation-complete pulse
//   o_ch_data             averaged code per channel, channel k at [8k+7:8k]
//   o_smp_valid, o_smp_ch pulse and channel index for each stored result
//   o_num                 mV value of the last stored result
//   o_scan_done           pulse after the last channel of a pass
//   o_err                 sticky I2C timeout flag
module pcf8591_scan #(
    parameter int CH_NUM      = 4,
    parameter int AVG_LOG2    = 2,
    parameter int VREF_MV     = 3300,
    parameter int GAP_CYC     = 16,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic                  i_dac_en,
    input  logic [7:0]            i_dac_val,
    output logic                  o_i2c_exec,
    output logic                  o_i2c_rh_wl,
    output logic [15:0]           o_i2c_addr,
    output logic [7:0]            o_i2c_data_w,
    input  logic [7:0]            i_i2c_data_r,
    input  logic                  i_i2c_done,
    output logic [CH_NUM*8-1:0]   o_ch_data,
    output logic                  o_smp_valid,
    output logic [1:0]            o_smp_ch,
    output logic [19:0]           o_num,
    output logic                  o_scan_done,
    output logic                  o_err
);
    typedef enum logic [2:0] {IDLE, GAP, EXEC, WAIT, STORE, NEXT} state_t;
    localparam logic [1:0] PH_WR = 2'd0, PH_DUM = 2'd1, PH_RD = 2'd2;
    localparam int AW = 8 + AVG_LOG2;
    state_t          r_state, w_next;
    logic [1:0]      r_ch, r_phase;
    logic [4:0]      r_rd_cnt;
    logic [31:0]     r_gap_cnt, r_to_cnt;
    logic [AW-1:0]   r_acc;
    logic [7:0]      r_addr, r_data_w;
    logic            r_rh_wl;
    logic [CH_NUM*8-1:0] r_ch_data;
    logic            r_smp_valid, r_scan_done, r_err;
    logic [1:0]      r_smp_ch;
    logic [19:0]     r_num;
    logic            w_done, w_to, w_last, w_gap_end, w_wrap;
    logic [7:0]      w_avg;
    logic [27:0]     w_prod;
    assign w_done    = r_state == WAIT && i_i2c_done;
    // done wins over a timeout terminal count in the same cycle
    assign w_to      = r_state == WAIT && !i_i2c_done && r_to_cnt == 32'(TIMEOUT_CYC - 1);
    assign w_last    = r_phase == PH_RD && r_rd_cnt == 5'((1 << AVG_LOG2) - 1);
    assign w_gap_end = r_gap_cnt == 32'(GAP_CYC - 1);
    assign w_wrap    = r_ch == 2'(CH_NUM - 1);
    assign w_avg     = 8'(r_acc >> AVG_LOG2);
    assign w_prod    = 28'(w_avg) * 28'(VREF_MV);
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_enable ? GAP : IDLE;
            GAP:     w_next = !i_enable ? IDLE : (w_gap_end ? EXEC : GAP);
            EXEC:    w_next = WAIT;
            WAIT:    w_next = w_done ? (!i_enable ? IDLE : (w_last ? STORE : GAP)) : (w_to ? NEXT : WAIT);
            STORE:   w_next = NEXT;
            NEXT:    w_next = i_enable ? GAP : IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge i_clk)
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ch        <= '0;
            r_phase     <= PH_WR;
            r_rd_cnt    <= '0;
            r_gap_cnt   <= '0;
            r_to_cnt    <= '0;
            r_acc       <= '0;
            r_addr      <= '0;
            r_data_w    <= '0;
            r_rh_wl     <= 1'b0;
            r_ch_data   <= '0;
            r_smp_valid <= 1'b0;
            r_smp_ch    <= '0;
            r_num       <= '0;
            r_scan_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_smp_valid <= 1'b0;
            r_scan_done <= 1'b0;
            r_gap_cnt   <= r_state == GAP ? r_gap_cnt + 32'd1 : '0;
            r_to_cnt    <= r_state == WAIT ? r_to_cnt + 32'd1 : '0;
            // operation fields are set on entry to EXEC and held until the next one
            if (r_state == GAP && w_next == EXEC) begin
                r_rh_wl <= r_phase != PH_WR;
                if (r_phase == PH_WR) begin
                    r_addr   <= {1'b0, i_dac_en, 4'b0000, r_ch};
                    r_data_w <= i_dac_val;
                    r_acc    <= '0;
                end
            end
            if (w_done) begin
                r_phase  <= r_phase == PH_WR ? PH_DUM : PH_RD;
                r_rd_cnt <= r_phase == PH_RD ? r_rd_cnt + 5'd1 : '0;
                if (r_phase == PH_RD) r_acc <= r_acc + AW'(i_i2c_data_r);
            end
            if (w_to) r_err <= 1'b1;
            if (r_state == STORE) begin
                r_ch_data[{r_ch, 3'b000} +: 8] <= w_avg;
                r_num       <= w_prod[27:8];
                r_smp_valid <= 1'b1;
                r_smp_ch    <= r_ch;
            end
            if (r_state == NEXT) begin
                r_ch        <= w_wrap ? 2'd0 : r_ch + 2'd1;
                r_scan_done <= w_wrap;
                r_phase     <= PH_WR;
            end
            // a visit interrupted by disable restarts from its write
            if (r_state == IDLE) begin
                r_phase  <= PH_WR;
                r_rd_cnt <= '0;
            end
        end
    end
    assign o_i2c_exec   = r_state == EXEC;
    assign o_i2c_rh_wl  = r_rh_wl;
    assign o_i2c_addr   = {8'h00, r_addr};
    assign o_i2c_data_w = r_data_w;
    assign o_ch_data    = r_ch_data;
    assign o_smp_valid  = r_smp_valid;
    assign o_smp_ch     = r_smp_ch;
    assign o_num        = r_num;
    assign o_scan_done  = r_scan_done;
    assign o_err        = r_err;
endmodule

// File: tb/tb_pcf8591_scan.sv
// tb_pcf8591_scan: scoreboard bench for pcf8591_scan with a simple I2C responder model.
module tb_pcf8591_scan;
    logic        clk = 0, rst = 1, enable = 0, dac_en = 0;
    logic [7:0]  dac_val = 0;
    logic        exec, rh_wl, smp_valid, scan_done, err;
    logic [15:0] addr;
    logic [7:0]  data_w, m_data = 0;
    logic        m_done = 0, s_done = 0, done;
    logic [31:0] ch_data;
    logic [1:0]  smp_ch;
    logic [19:0] num;
    assign done = m_done | s_done;
    always #5 clk = ~clk;

    pcf8591_scan #(.CH_NUM(4), .AVG_LOG2(2), .VREF_MV(3300), .GAP_CYC(4), .TIMEOUT_CYC(200)) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_dac_en(dac_en), .i_dac_val(dac_val),
        .o_i2c_exec(exec), .o_i2c_rh_wl(rh_wl), .o_i2c_addr(addr), .o_i2c_data_w(data_w),
        .i_i2c_data_r(m_data), .i_i2c_done(done), .o_ch_data(ch_data), .o_smp_valid(smp_valid),
        .o_smp_ch(smp_ch), .o_num(num), .o_scan_done(scan_done), .o_err(err));

    int checks = 0, errors = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {logic [1:0] ch; logic [7:0] avg; logic [19:0] num;} exp_t;
    exp_t sb[$];
    task automatic push(input logic [1:0] c, input logic [7:0] a, input logic [19:0] n);
        sb.push_back('{c, a, n});
    endtask

    // I2C responder: done 3 cycles after exec; dummy read returns 0xAA
    logic [7:0] rd_tab [4][4];
    int withhold = -1;
    bit m_off = 0;
    initial begin
        int idx;
        logic [1:0] c;
        logic rd;
        idx = -1;
        forever begin
            @(negedge clk);
            if (exec && !m_off) begin
                c = addr[1:0];
                rd = rh_wl;
                if (!rd) idx = -1;
                if (int'(c) != withhold) begin
                    repeat (3) @(negedge clk);
                    m_data = !rd ? 8'h00 : (idx < 0 ? 8'hAA : rd_tab[c][idx]);
                    m_done = 1;
                    @(negedge clk);
                    m_done = 0;
                end
                if (rd && idx < 3) idx++;
            end
        end
    end

    // monitors: scoreboard on smp_valid, write-field checks, timeout latency
    int cyc = 0, t_exec = 0, scan_cnt = 0, exec_cnt = 0;
    bit err_seen = 0;
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (scan_done) scan_cnt++;
        if (exec) exec_cnt++;
        if (exec && !rh_wl) begin
            chk("wr_addr_hi", {16'h0, addr & 16'hfffc}, dac_en ? 32'h40 : 32'h0);
            chk("wr_data", {24'h0, data_w}, {24'h0, dac_val});
            if (withhold == 2 && addr[1:0] == 2'd2) t_exec = cyc;
        end
        if (err && !err_seen) begin
            err_seen = 1;
            chk("err_latency", cyc - t_exec, 201);
        end
        if (smp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_smp actual_ch=%0d expected=none", smp_ch);
            end else begin
                e = sb.pop_front();
                chk("smp_ch", {30'h0, smp_ch}, {30'h0, e.ch});
                chk("num", {12'h0, num}, {12'h0, e.num});
                chk("ch_slot", {24'h0, ch_data[8*e.ch +: 8]}, {24'h0, e.avg});
            end
        end
    end

    task automatic wait_scan(input int exp_cnt);
        int n = 0;
        while (scan_cnt != exp_cnt && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("scan_cnt", scan_cnt, exp_cnt);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_exec"}, {31'h0, exec}, 0);
        chk({tag, "_addr"}, {16'h0, addr}, 0);
        chk({tag, "_data_w"}, {24'h0, data_w}, 0);
        chk({tag, "_rh_wl"}, {31'h0, rh_wl}, 0);
        chk({tag, "_ch_data"}, ch_data, 0);
        chk({tag, "_num"}, {12'h0, num}, 0);
        chk({tag, "_err"}, {31'h0, err}, 0);
        chk({tag, "_pulses"}, {29'h0, smp_valid, scan_done, |smp_ch}, 0);
    endtask

    initial begin
        int n;
        for (int k = 0; k < 4; k++) begin
            rd_tab[1][k] = 8'h40;
            rd_tab[2][k] = 8'h80;
            rd_tab[3][k] = 8'hFF;
        end
        rd_tab[0][0] = 8'd10; rd_tab[0][1] = 8'd11; rd_tab[0][2] = 8'd12; rd_tab[0][3] = 8'd14;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 0;
        // pass 1: dac on, ch0 averages (10+11+12+14)>>2 = 11 -> 141 mV
        dac_en = 1; dac_val = 8'h5A;
        push(0, 8'd11, 20'd141); push(1, 8'h40, 20'd825); push(2, 8'h80, 20'd1650); push(3, 8'hFF, 20'd3287);
        enable = 1;
        wait_scan(1);
        enable = 0;
        repeat (20) @(negedge clk);
        chk("pass1_ch_data", ch_data, 32'hFF80400B);
        chk("pass1_err", {31'h0, err}, 0);
        // pass 2: dac off, ch0 constant 0x10 -> 206 mV
        for (int k = 0; k < 4; k++) rd_tab[0][k] = 8'h10;
        dac_en = 0; dac_val = 8'h33;
        push(0, 8'h10, 20'd206); push(1, 8'h40, 20'd825); push(2, 8'h80, 20'd1650); push(3, 8'hFF, 20'd3287);
        enable = 1;
        wait_scan(2);
        enable = 0;
        repeat (20) @(negedge clk);
        chk("pass2_ch_data", ch_data, 32'hFF804010);
        // pass 3: ch2 never answers -> timeout, ch2 slot kept, no ch2 sample
        withhold = 2;
        push(0, 8'h10, 20'd206); push(1, 8'h40, 20'd825); push(3, 8'hFF, 20'd3287);
        enable = 1;
        wait_scan(3);
        enable = 0;
        repeat (20) @(negedge clk);
        withhold = -1;
        chk("timeout_err", {31'h0, err}, 1);
        chk("timeout_ch_data", ch_data, 32'hFF804010);
        chk("timeout_err_seen", {31'h0, err_seen}, 1);
        // pass 4: drop enable on the second read of ch1 (4th op of that visit)
        push(0, 8'h10, 20'd206);
        enable = 1;
        n = 0;
        for (int t = 0; t < 2000 && n < 4; t++) begin
            @(negedge clk);
            if (exec && addr[1:0] == 2'd1) n++;
        end
        chk("disable_point", n, 4);
        enable = 0;
        repeat (12) @(negedge clk);
        n = exec_cnt;
        repeat (40) @(negedge clk);
        chk("idle_no_exec", exec_cnt, n);
        chk("disable_sb_empty", sb.size(), 0);
        push(1, 8'h40, 20'd825); push(2, 8'h80, 20'd1650); push(3, 8'hFF, 20'd3287);
        enable = 1;
        n = 0;
        while (!exec && n < 200) begin @(negedge clk); n++; end
        chk("resume_is_write", {31'h0, rh_wl}, 0);
        chk("resume_ch", {30'h0, addr[1:0]}, 1);
        wait_scan(4);
        enable = 0;
        repeat (20) @(negedge clk);
        chk("pass4_ch_data", ch_data, 32'hFF804010);
        chk("sb_drained", sb.size(), 0);
        // reset while in WAIT, then late done pulses
        m_off = 1;
        enable = 1;
        n = 0;
        while (!exec && n < 200) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        rst = 1; s_done = 1;
        @(negedge clk);
        s_done = 0;
        @(negedge clk);
        enable = 0; rst = 0;
        repeat (2) @(negedge clk);
        s_done = 1;
        @(negedge clk);
        s_done = 0;
        repeat (3) @(negedge clk);
        check_zero("rst_wait");
        enable = 1;
        n = 0;
        while (!exec && n < 200) begin @(negedge clk); n++; end
        chk("post_rst_write", {31'h0, rh_wl}, 0);
        chk("post_rst_ch", {30'h0, addr[1:0]}, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
